// File: rtl/driver_motor_pwm_pkg.sv
// Shared constants for the H-bridge PWM driver: direction codes, BCD limit,
// FSM state encoding and the BCD duty clamp helper.
package driver_motor_pwm_pkg;

    localparam logic [1:0]  DIR_INAINTE = 2'b10;
    localparam logic [1:0]  DIR_INAPOI  = 2'b01;
    localparam logic [1:0]  DIR_STOP    = 2'b00;
    localparam logic [1:0]  DIR_FRANA   = 2'b11;

    localparam logic [11:0] BCD_MAX     = 12'h999;

    localparam logic [1:0]  ST_INACTIV  = 2'd0;
    localparam logic [1:0]  ST_MERS     = 2'd1;
    localparam logic [1:0]  ST_PAUZA    = 2'd2;

    // Any BCD digit above 9 saturates to 9.
    function automatic logic [11:0] clamp_bcd(input logic [11:0] v);
        logic [11:0] r;
        r = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            r[i*4 +: 4] = (v[i*4 +: 4] > 4'd9) ? 4'd9 : v[i*4 +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/numarator_bcd.sv
// Three-digit BCD period counter (000..999) advancing on en_tic, with a
// combinational wrap event and a registered one-clk period pulse.
module numarator_bcd
    import driver_motor_pwm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_tic,
    output logic [11:0] numar_urm,
    output logic        wrap,
    output logic        perioada_gata
);

    logic [11:0] numar_q, numar_d;
    logic        gata_q, gata_d;

    always_comb begin
        numar_d = numar_q;
        wrap    = en_tic && (numar_q == BCD_MAX);
        if (en_tic) begin
            if (numar_q == BCD_MAX) begin
                numar_d = '0;
            end else if (numar_q[3:0] != 4'd9) begin
                numar_d[3:0] = numar_q[3:0] + 4'd1;
            end else begin
                numar_d[3:0] = '0;
                if (numar_q[7:4] != 4'd9) begin
                    numar_d[7:4] = numar_q[7:4] + 4'd1;
                end else begin
                    numar_d[7:4]  = '0;
                    numar_d[11:8] = numar_q[11:8] + 4'd1;
                end
            end
        end
        gata_d = wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            numar_q <= '0;
            gata_q  <= 1'b0;
        end else begin
            numar_q <= numar_d;
            gata_q  <= gata_d;
        end
    end

    assign numar_urm     = numar_d;
    assign perioada_gata = gata_q;

endmodule

// File: rtl/driver_motor_pwm.sv
// H-bridge PWM driver: samples direction/duty at each period wrap, inserts a
// dead-time pause of TIMP_MORT periods on a direct forward/reverse reversal.
module driver_motor_pwm
    import driver_motor_pwm_pkg::*;
#(
    parameter int unsigned TIMP_MORT = 2
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_tic,
    input  logic [1:0]  directie_cmd,
    input  logic [11:0] factor_dc_cmd,
    output logic        in1,
    output logic        in2,
    output logic        pwm_en,
    output logic [1:0]  directie_activa,
    output logic        timp_mort,
    output logic        perioada_gata
);

    logic [11:0] numar_urm;
    logic        wrap;

    numarator_bcd u_numarator (
        .clk           (clk),
        .rst           (rst),
        .en_tic        (en_tic),
        .numar_urm     (numar_urm),
        .wrap          (wrap),
        .perioada_gata (perioada_gata)
    );

    logic [1:0]  stare_q, stare_d;
    logic [1:0]  dir_q, dir_d;
    logic [11:0] factor_q, factor_d;
    logic [3:0]  pauza_q, pauza_d;
    logic        in1_q, in1_d, in2_q, in2_d, pwm_q, pwm_d, mort_q, mort_d;
    logic        inversare;

    always_comb begin
        stare_d  = stare_q;
        dir_d    = dir_q;
        factor_d = factor_q;
        pauza_d  = pauza_q;

        inversare = (dir_q == DIR_INAINTE && directie_cmd == DIR_INAPOI) ||
                    (dir_q == DIR_INAPOI  && directie_cmd == DIR_INAINTE);

        if (wrap) begin
            factor_d = clamp_bcd(factor_dc_cmd);
            case (stare_q)
                ST_MERS: begin
                    if (inversare) begin
                        stare_d = ST_PAUZA;
                        dir_d   = DIR_STOP;
                        pauza_d = '0;
                    end else begin
                        dir_d = directie_cmd;
                    end
                end
                ST_PAUZA: begin
                    if (pauza_q == 4'(TIMP_MORT - 1)) begin
                        stare_d = ST_MERS;
                        dir_d   = directie_cmd;
                        pauza_d = '0;
                    end else begin
                        pauza_d = pauza_q + 4'd1;
                    end
                end
                default: begin
                    stare_d = ST_MERS;
                    dir_d   = directie_cmd;
                end
            endcase
        end
    end

    // Pins are computed from next-cycle counter/state so the registered
    // outputs line up with the counter value they belong to.
    always_comb begin
        in1_d  = in1_q;
        in2_d  = in2_q;
        pwm_d  = pwm_q;
        mort_d = mort_q;
        if (en_tic) begin
            in1_d  = 1'b0;
            in2_d  = 1'b0;
            pwm_d  = 1'b0;
            mort_d = (stare_d == ST_PAUZA);
            if (stare_d == ST_MERS) begin
                in1_d = dir_d[1];
                in2_d = dir_d[0];
                case (dir_d)
                    DIR_INAINTE, DIR_INAPOI: pwm_d = (numar_urm < factor_d);
                    DIR_FRANA:               pwm_d = 1'b1;
                    default:                 pwm_d = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stare_q  <= ST_INACTIV;
            dir_q    <= DIR_STOP;
            factor_q <= '0;
            pauza_q  <= '0;
            in1_q    <= 1'b0;
            in2_q    <= 1'b0;
            pwm_q    <= 1'b0;
            mort_q   <= 1'b0;
        end else begin
            stare_q  <= stare_d;
            dir_q    <= dir_d;
            factor_q <= factor_d;
            pauza_q  <= pauza_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            pwm_q    <= pwm_d;
            mort_q   <= mort_d;
        end
    end

    assign in1             = in1_q;
    assign in2             = in2_q;
    assign pwm_en          = pwm_q;
    assign timp_mort       = mort_q;
    assign directie_activa = dir_q;

endmodule

// File: tb/tb_driver_motor_pwm.sv
// Randomized self-checking bench for driver_motor_pwm against a decimal
// period/tick reference model.
module tb_driver_motor_pwm;

    localparam int TM = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_tic;
    logic [1:0]  directie_cmd;
    logic [11:0] factor_dc_cmd;
    logic        in1, in2, pwm_en, timp_mort, perioada_gata;
    logic [1:0]  directie_activa;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    driver_motor_pwm #(.TIMP_MORT(TM)) dut (
        .clk             (clk),
        .rst             (rst),
        .en_tic          (en_tic),
        .directie_cmd    (directie_cmd),
        .factor_dc_cmd   (factor_dc_cmd),
        .in1             (in1),
        .in2             (in2),
        .pwm_en          (pwm_en),
        .directie_activa (directie_activa),
        .timp_mort       (timp_mort),
        .perioada_gata   (perioada_gata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: tick index 0..999, mode 0 idle / 1 running / 2 pausing.
    int m_cnt, m_mode, m_left, m_dir, m_duty;
    bit m_pg;

    function automatic int bcd_val(input logic [11:0] v);
        int r;
        r = 0;
        for (int i = 2; i >= 0; i--) begin
            int d;
            d = int'(v[i*4 +: 4]);
            if (d > 9) d = 9;
            r = r * 10 + d;
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_mode = 0; m_left = 0; m_dir = 0; m_duty = 0; m_pg = 0;
        end else if (en_tic) begin
            m_pg = (m_cnt == 999);
            if (m_cnt == 999) begin
                m_cnt = 0;
                if (m_mode == 0) begin
                    m_mode = 1; m_dir = int'(directie_cmd); m_duty = bcd_val(factor_dc_cmd);
                end else if (m_mode == 1) begin
                    if ((m_dir == 2 && directie_cmd == 2'b01) || (m_dir == 1 && directie_cmd == 2'b10)) begin
                        m_mode = 2; m_left = TM; m_dir = 0;
                    end else begin
                        m_dir = int'(directie_cmd); m_duty = bcd_val(factor_dc_cmd);
                    end
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = 1; m_dir = int'(directie_cmd); m_duty = bcd_val(factor_dc_cmd);
                    end
                end
            end else begin
                m_cnt++;
            end
        end else begin
            m_pg = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic i1, i2, p;
            i1 = 0; i2 = 0; p = 0;
            if (m_mode == 1) begin
                case (m_dir)
                    2: begin i1 = 1; p = (m_cnt < m_duty); end
                    1: begin i2 = 1; p = (m_cnt < m_duty); end
                    3: begin i1 = 1; i2 = 1; p = 1; end
                    default: ;
                endcase
            end
            chk("pins", {29'd0, in1, in2, pwm_en}, {29'd0, i1, i2, p});
            chk("dir", {30'd0, directie_activa}, (m_mode == 1) ? m_dir : 0);
            chk("timp_mort", {31'd0, timp_mort}, {31'd0, m_mode == 2});
            chk("perioada_gata", {31'd0, perioada_gata}, {31'd0, m_pg});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_for(input int mode, input int cnt, input string tag);
        int n;
        n = 0;
        while (!((mode < 0 || m_mode == mode) && m_cnt == cnt) && n < 6000) begin
            step(1);
            n++;
        end
        chk(tag, {31'd0, n < 6000}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; en_tic = 1'b0; directie_cmd = 2'b00; factor_dc_cmd = 12'h000;
        step(3);
        chk("rst_pins", {29'd0, in1, in2, pwm_en}, 32'd0);
        chk("rst_dir", {30'd0, directie_activa}, 32'd0);
        chk("rst_flags", {30'd0, timp_mort, perioada_gata}, 32'd0);
        rst = 1'b0;
        chk_on = 1'b1;

        en_tic = 1'b1; directie_cmd = 2'b10; factor_dc_cmd = 12'h650;
        step(2500);
        wait_for(-1, 300, "wait_cnt300");
        factor_dc_cmd = 12'h800;
        step(1000);
        directie_cmd = 2'b01; factor_dc_cmd = 12'h650;
        step(3600);
        directie_cmd = 2'b10;
        step(4200);
        factor_dc_cmd = 12'h9A5; step(1500);
        factor_dc_cmd = 12'h000; step(1000);
        directie_cmd  = 2'b11;   step(1000);
        directie_cmd  = 2'b00;   step(1000);

        directie_cmd = 2'b10; factor_dc_cmd = 12'h650; step(1000);
        directie_cmd = 2'b01;
        wait_for(2, 500, "wait_pause500");
        rst = 1'b1; step(2);
        rst = 1'b0; step(2500);

        for (int k = 0; k < 8200; k++) begin
            en_tic = (k % 4 == 0);
            step(1);
        end

        for (int k = 0; k < 20000; k++) begin
            en_tic = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) directie_cmd = 2'($urandom);
            if ($urandom_range(0, 299) == 0) factor_dc_cmd = 12'($urandom);
            rst = ($urandom_range(0, 4999) == 0);
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
